// File: rtl/traffic_lights.sv
// traffic_lights: red/yellow/green controller on a 2 kHz tick with off and blinking-yellow modes.
// Define TRAFFIC_LIGHTS_CFG_ANY_STATE_EN to accept time-config commands in every state
// instead of only in the unregulated (blinking yellow) mode.
module traffic_lights #(
    parameter int BLINK_HALF_PERIOD_MS  = 10,
    parameter int BLINK_GREEN_TIME_TICK = 2,
    parameter int RED_YELLOW_MS         = 15,
    parameter int DEFAULT_GREEN_MS      = 1000,
    parameter int DEFAULT_RED_MS        = 1000,
    parameter int DEFAULT_YELLOW_MS     = 1000
) (
    input  logic        clk_0m002,
    input  logic        srst_i,
    input  logic [2:0]  cmd_type_i,
    input  logic        cmd_val_i,
    input  logic [15:0] cmd_data_i,
    output logic        red_o,
    output logic        yellow_o,
    output logic        green_o
);
    typedef enum logic [2:0] {
        OFF, RED, RED_YELLOW, GREEN, GREEN_BLINK, YELLOW, NOTRANSITION
    } state_t;

    localparam logic [16:0] HALF_TICKS = 17'(BLINK_HALF_PERIOD_MS * 2);
    localparam logic [16:0] RY_TICKS   = (RED_YELLOW_MS == 0) ? 17'd1 : 17'(RED_YELLOW_MS * 2);
    localparam int          NW         = $clog2(2 * BLINK_GREEN_TIME_TICK) + 1;
    localparam logic [NW-1:0] LAST_HALF = NW'(2 * BLINK_GREEN_TIME_TICK - 1);

    state_t        state, state_nxt;
    logic [16:0]   cnt, cnt_nxt;
    logic [16:0]   len, len_nxt;
    logic [NW-1:0] half, half_nxt;
    logic [15:0]   green_ms, red_ms, yellow_ms;
    logic          mode_cmd, entry, cfg_en;

    // ms to ticks; a stored zero still yields a one-tick phase
    function automatic logic [16:0] to_ticks(input logic [15:0] ms);
        return (ms == 16'd0) ? 17'd1 : {ms, 1'b0};
    endfunction

`ifdef TRAFFIC_LIGHTS_CFG_ANY_STATE_EN
    assign cfg_en = cmd_val_i;
`else
    assign cfg_en = cmd_val_i && (state == NOTRANSITION);
`endif

    assign mode_cmd = cmd_val_i && (cmd_type_i <= 3'd2);

    // state register, phase counter, blink half counter and latched phase length
    always_ff @(posedge clk_0m002 or posedge srst_i) begin
        if (srst_i) begin
            state <= OFF;
            cnt   <= '0;
            half  <= '0;
            len   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            half  <= half_nxt;
            len   <= len_nxt;
        end
    end

    // phase times; a new value is only picked up when its phase is next entered
    always_ff @(posedge clk_0m002 or posedge srst_i) begin
        if (srst_i) begin
            green_ms  <= 16'(DEFAULT_GREEN_MS);
            red_ms    <= 16'(DEFAULT_RED_MS);
            yellow_ms <= 16'(DEFAULT_YELLOW_MS);
        end else begin
            if (cfg_en && cmd_type_i == 3'd3) green_ms  <= cmd_data_i;
            if (cfg_en && cmd_type_i == 3'd4) red_ms    <= cmd_data_i;
            if (cfg_en && cmd_type_i == 3'd5) yellow_ms <= cmd_data_i;
        end
    end

    // next state: phase expiry first, then mode commands override it
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 17'd1;
        half_nxt  = half;
        case (state)
            OFF: cnt_nxt = cnt;
            RED, RED_YELLOW, GREEN, YELLOW:
                if (cnt == len - 17'd1)
                    state_nxt = (state == RED)        ? RED_YELLOW :
                                (state == RED_YELLOW) ? GREEN :
                                (state == GREEN)      ? GREEN_BLINK : RED;
            GREEN_BLINK, NOTRANSITION:
                if (cnt == HALF_TICKS - 17'd1) begin
                    cnt_nxt  = '0;
                    half_nxt = half + 1'b1;
                    if (state == GREEN_BLINK && half == LAST_HALF) state_nxt = YELLOW;
                end
            default: state_nxt = OFF;
        endcase
        if (mode_cmd)
            state_nxt = (cmd_type_i == 3'd0) ? RED : (cmd_type_i == 3'd1) ? OFF : NOTRANSITION;
        entry = mode_cmd || (state_nxt != state);
        if (entry) begin
            cnt_nxt  = '0;
            half_nxt = '0;
        end
        len_nxt = !entry                   ? len :
                  (state_nxt == RED)        ? to_ticks(red_ms) :
                  (state_nxt == RED_YELLOW) ? RY_TICKS :
                  (state_nxt == GREEN)      ? to_ticks(green_ms) :
                  (state_nxt == YELLOW)     ? to_ticks(yellow_ms) : 17'd1;
    end

    // lamps: blinking phases are lit during even half periods
    always_comb begin
        red_o    = (state == RED) || (state == RED_YELLOW);
        yellow_o = (state == RED_YELLOW) || (state == YELLOW) || (state == NOTRANSITION && !half[0]);
        green_o  = (state == GREEN) || (state == GREEN_BLINK && !half[0]);
    end
endmodule

// File: tb/tb_traffic_lights.sv
// tb_traffic_lights: directed self-checking bench for traffic_lights.
module tb_traffic_lights;
    logic        clk_0m002 = 1'b0;
    logic        srst_i = 1'b1;
    logic [2:0]  cmd_type_i = '0;
    logic        cmd_val_i = 1'b0;
    logic [15:0] cmd_data_i = '0;
    logic        red_o, yellow_o, green_o;
    logic [2:0]  lamps;
    int          checks = 0;
    int          errors = 0;

    traffic_lights dut (
        .clk_0m002 (clk_0m002),
        .srst_i    (srst_i),
        .cmd_type_i(cmd_type_i),
        .cmd_val_i (cmd_val_i),
        .cmd_data_i(cmd_data_i),
        .red_o     (red_o),
        .yellow_o  (yellow_o),
        .green_o   (green_o)
    );

    assign lamps = {red_o, yellow_o, green_o};

    always #5 clk_0m002 = ~clk_0m002;

    // expected {R,Y,G} k cycles after entering RED: red rl, red+yellow 30, green gl,
    // two 20-on/20-off green blinks, yellow 20, then red again
    function automatic logic [2:0] exp_cyc(input int k, input int rl, input int gl);
        int t;
        t = k;
        if (t < rl) return 3'b100;
        t = t - rl;
        if (t < 30) return 3'b110;
        t = t - 30;
        if (t < gl) return 3'b001;
        t = t - gl;
        if (t < 80) return ((t / 20) % 2 == 0) ? 3'b001 : 3'b000;
        t = t - 80;
        if (t < 20) return 3'b010;
        return 3'b100;
    endfunction

    task automatic send(input logic [2:0] t, input logic [15:0] d);
        @(negedge clk_0m002);
        cmd_type_i = t;
        cmd_data_i = d;
        cmd_val_i  = 1'b1;
        @(posedge clk_0m002);
        #1 cmd_val_i = 1'b0;
    endtask

    task automatic test_reset();
        srst_i = 1'b1;
        repeat (2) @(negedge clk_0m002);
        checks++;
        if (lamps !== 3'b000) begin
            errors++;
            $display("FAIL reset_held got %b expected 000", lamps);
        end
        srst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_0m002);
            checks++;
            if (lamps !== 3'b000) begin
                errors++;
                $display("FAIL reset_idle k=%0d got %b expected 000", k, lamps);
            end
        end
    endtask

    task automatic test_unreg();
        logic [2:0] e;
        send(3'd2, 16'd0);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk_0m002);
            e = ((k / 20) % 2 == 0) ? 3'b010 : 3'b000;
            checks++;
            if (lamps !== e) begin
                errors++;
                $display("FAIL unreg k=%0d got %b expected %b", k, lamps, e);
            end
        end
    endtask

    task automatic test_cycle();
        logic [2:0] e;
        send(3'd3, 16'd10);
        send(3'd4, 16'd10);
        send(3'd5, 16'd10);
        send(3'd0, 16'd0);
        for (int k = 0; k < 340; k++) begin
            @(negedge clk_0m002);
            e = exp_cyc(k % 170, 20, 20);
            checks++;
            if (lamps !== e) begin
                errors++;
                $display("FAIL cycle k=%0d got %b expected %b", k, lamps, e);
            end
        end
    endtask

    task automatic test_cfg_in_red();
        logic [2:0] e;
        int rl2;
`ifdef TRAFFIC_LIGHTS_CFG_ANY_STATE_EN
        rl2 = 200;
`else
        rl2 = 20;
`endif
        send(3'd0, 16'd0);
        send(3'd4, 16'd100);
        for (int k = 1; k < 170; k++) begin
            @(negedge clk_0m002);
            e = exp_cyc(k, 20, 20);
            checks++;
            if (lamps !== e) begin
                errors++;
                $display("FAIL cfg_red_cur k=%0d got %b expected %b", k, lamps, e);
            end
        end
        for (int k = 0; k <= rl2; k++) begin
            @(negedge clk_0m002);
            e = exp_cyc(k, rl2, 20);
            checks++;
            if (lamps !== e) begin
                errors++;
                $display("FAIL cfg_red_next k=%0d got %b expected %b", k, lamps, e);
            end
        end
    endtask

    task automatic test_ignored_codes();
        logic [2:0] e;
        send(3'd2, 16'd0);
        send(3'd4, 16'd10);
        send(3'd0, 16'd0);
        send(3'd6, 16'd555);
        send(3'd7, 16'd1);
        for (int k = 2; k < 22; k++) begin
            @(negedge clk_0m002);
            e = exp_cyc(k, 20, 20);
            checks++;
            if (lamps !== e) begin
                errors++;
                $display("FAIL codes67 k=%0d got %b expected %b", k, lamps, e);
            end
        end
    endtask

    task automatic test_off();
        logic [2:0] e;
        send(3'd0, 16'd0);
        for (int k = 0; k < 55; k++) begin
            @(negedge clk_0m002);
            e = exp_cyc(k, 20, 20);
            checks++;
            if (lamps !== e) begin
                errors++;
                $display("FAIL pre_off k=%0d got %b expected %b", k, lamps, e);
            end
        end
        send(3'd1, 16'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_0m002);
            checks++;
            if (lamps !== 3'b000) begin
                errors++;
                $display("FAIL off k=%0d got %b expected 000", k, lamps);
            end
        end
    endtask

    task automatic test_zero_green();
        logic [2:0] e;
        send(3'd2, 16'd0);
        send(3'd3, 16'd0);
        send(3'd0, 16'd0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_0m002);
            e = exp_cyc(k, 20, 1);
            checks++;
            if (lamps !== e) begin
                errors++;
                $display("FAIL zero_green k=%0d got %b expected %b", k, lamps, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] e;
        send(3'd2, 16'd0);
        send(3'd3, 16'd10);
        send(3'd0, 16'd0);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk_0m002);
            e = exp_cyc(k, 20, 20);
            checks++;
            if (lamps !== e) begin
                errors++;
                $display("FAIL pre_reset k=%0d got %b expected %b", k, lamps, e);
            end
        end
        #2 srst_i = 1'b1;
        #1;
        checks++;
        if (lamps !== 3'b000) begin
            errors++;
            $display("FAIL async_reset got %b expected 000", lamps);
        end
        @(negedge clk_0m002);
        srst_i = 1'b0;
        @(negedge clk_0m002);
        checks++;
        if (lamps !== 3'b000) begin
            errors++;
            $display("FAIL after_reset got %b expected 000", lamps);
        end
        send(3'd0, 16'd0);
        for (int k = 0; k <= 2000; k++) begin
            @(negedge clk_0m002);
            e = (k < 2000) ? 3'b100 : 3'b110;
            checks++;
            if (lamps !== e) begin
                errors++;
                $display("FAIL default_red k=%0d got %b expected %b", k, lamps, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unreg();
        test_cycle();
        test_cfg_in_red();
        test_ignored_codes();
        test_off();
        test_zero_green();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_lights.md
Name: traffic_lights

Overview:
- Traffic-light controller driven by a 2 kHz tick clock (one tick = 0.5 ms).
- Runs the cycle red -> red+yellow -> green -> blinking green -> yellow -> red.
- Also supports an off mode and an unregulated mode with blinking yellow.
- Controlled by a host command bus; phase times are configurable in milliseconds; sits at the top level, driving three lamp outputs directly.

Parameters:
- BLINK_HALF_PERIOD_MS, 10, half-period (ms) of any blink, for green blink and yellow blink alike.
- BLINK_GREEN_TIME_TICK, 2, number of complete green blinks (on+off periods) after the steady green phase.
- RED_YELLOW_MS, 15, fixed duration (ms) of the red+yellow phase.
- DEFAULT_GREEN_MS, 1000, green time after reset.
- DEFAULT_RED_MS, 1000, red time after reset.
- DEFAULT_YELLOW_MS, 1000, yellow time after reset.

Ports:
- clk_0m002  in  1  2 kHz clock, all logic on rising edge.
- srst_i  in  1  reset; one clock; asynchronous, active-high.
- cmd_type_i  in  3  command code, sampled when cmd_val_i=1.
- cmd_val_i  in  1  command valid, single-cycle strobe, no backpressure.
- cmd_data_i  in  16  time argument in ms for codes 3/4/5; ignored otherwise.
- red_o  out  1  red lamp.
- yellow_o  out  1  yellow lamp.
- green_o  out  1  green lamp.

Behaviour:
- Tick conversion: ticks = ms*2, using 17-bit arithmetic, no overflow for 16-bit ms. A stored value of 0 behaves as 1 tick.
- Command codes:
  - 0 ON: enter RED, timers cleared.
  - 1 OFF: enter OFF.
  - 2 UNREG: enter NOTRANSITION.
  - 3 set green ms.
  - 4 set red ms.
  - 5 set yellow ms.
  - 6/7 ignored.
- Config codes 3/4/5 are accepted only in NOTRANSITION; in other states they are ignored.
- A new config value takes effect on the next entry into the corresponding phase.
- Codes 0/1/2 are accepted from any state, including re-issuing the current mode, which restarts that mode from its beginning.
- A command sampled at edge N changes the state at edge N. Lamps are decoded combinationally from the state and counters, so new lamps are visible after edge N.
- States and lamps (R,Y,G):
  - OFF: 000, stays until a command.
  - RED: 100, lasts red ticks, then RED_YELLOW.
  - RED_YELLOW: 110, lasts RED_YELLOW_MS*2 ticks, then GREEN.
  - GREEN: 001, lasts green ticks, then GREEN_BLINK.
  - GREEN_BLINK: BLINK_GREEN_TIME_TICK periods. Each period is green on for BLINK_HALF_PERIOD_MS*2 ticks, then off for the same. Then YELLOW.
  - YELLOW: 010, lasts yellow ticks, then RED.
  - NOTRANSITION: red=green=0. Yellow is on for BLINK_HALF_PERIOD_MS*2 ticks, then off for the same, repeating and starting on.
- Phase counter: cleared on every state entry. A phase of T ticks shows its lamps for exactly T clock cycles.
- Reset (asynchronous, any time):
  - State OFF, all outputs 0.
  - Counters 0.
  - Time registers load DEFAULT_*_MS.
- Simultaneous command and phase expiry: the command wins.

Optional Feature:
- Macro TRAFFIC_LIGHTS_CFG_ANY_STATE_EN.
- Defined: codes 3/4/5 are accepted in every state. A running phase keeps its original duration; the new value applies from the next entry into that phase.
- Undefined: codes 3/4/5 are accepted only in NOTRANSITION, as above.

Test Plan:
- Reset, then 3 idle cycles -> R,Y,G = 000. Pulse cmd 2 -> yellow=1 for 20 cycles, 0 for 20 cycles, repeating; red=green=0.
- In NOTRANSITION, cmds 3/4/5 with data 10, then cmd 0, giving these phases in order, with a total cycle of 170 ticks that repeats:
  - red 20 cycles;
  - red+yellow 30 cycles;
  - green 20 cycles;
  - green 20 on / 20 off, twice;
  - yellow 20 cycles.
- While in RED, cmd 4 with data 100 (macro undefined) -> ignored, red still 20 cycles. With macro defined -> next red phase lasts 200 cycles.
- Pulse cmd 1 mid-GREEN -> 000 from the sampling edge onward. Cmd 6 or 7 -> no change.
- Cmd 3 with data 0 in NOTRANSITION, then cmd 0 -> green phase lasts exactly 1 cycle.
- Assert srst_i asynchronously mid-GREEN_BLINK -> outputs go to 000 immediately. After release, cmd 0 uses default times (red 2000 cycles).
